// File: rtl/id_ex_stage.sv
// id_ex_stage: pipeline register between register-file read (decode) and execute.
//
// Captures both 16-bit operands, the immediate, the destination index and an
// opaque control bundle. Resolves the same-cycle writeback hazard against the
// register file, detects load-use hazards (inserting a one-cycle bubble), and
// honours the downstream hold and the flush.
//
// Build option: WB_BYPASS_EN
//   defined   - writeback data is muxed straight into the operands.
//   undefined - operands always come from the register file; an instruction
//               reading a register being written this cycle is stalled for one
//               cycle so that it rereads the committed value.
//
// Ports:
//   clk, reset (async, active-low)
//   id_*          decode-stage instruction fields
//   rf_data1/2    register file read data for id_rs1/id_rs2
//   wb_*          register file write port nets
//   ex_hold       downstream stall, all ex_* retained
//   flush         kill the instruction entering EX
//   hazard_stall  combinational, upstream holds PC and ID
//   ex_*          registered outputs to execute
module id_ex_stage #(
  parameter int unsigned CTRL_W   = 8,
  parameter logic [3:0]  ZERO_REG = 4'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [3:0]        id_rs1,
  input  logic [3:0]        id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [15:0]       rf_data1,
  input  logic [15:0]       rf_data2,
  input  logic [15:0]       id_imm,
  input  logic [3:0]        id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_reg_write,
  input  logic [3:0]        wb_write_reg,
  input  logic [15:0]       wb_write_data,
  input  logic              ex_hold,
  input  logic              flush,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [15:0]       ex_op_a,
  output logic [15:0]       ex_op_b,
  output logic [15:0]       ex_imm,
  output logic [3:0]        ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [CTRL_W-1:0] ex_ctrl
);

  logic              ex_valid_q, ex_valid_d;
  logic [15:0]       ex_op_a_q, ex_op_a_d;
  logic [15:0]       ex_op_b_q, ex_op_b_d;
  logic [15:0]       ex_imm_q, ex_imm_d;
  logic [3:0]        ex_rd_q, ex_rd_d;
  logic              ex_reg_write_q, ex_reg_write_d;
  logic              ex_mem_read_q, ex_mem_read_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;

  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        load_use;
  logic        wb_hazard;

`ifdef WB_BYPASS_EN
  // The register file commits on the same edge we sample, so its read data
  // is stale for a register being written this cycle.
  always_comb begin
    op_a = rf_data1;
    op_b = rf_data2;
    if (wb_reg_write && (wb_write_reg == id_rs1) && (id_rs1 != ZERO_REG)) begin
      op_a = wb_write_data;
    end
    if (wb_reg_write && (wb_write_reg == id_rs2) && (id_rs2 != ZERO_REG)) begin
      op_b = wb_write_data;
    end
  end

  assign wb_hazard = 1'b0;
`else
  logic unused_wb_write_data;

  assign op_a = rf_data1;
  assign op_b = rf_data2;
  assign unused_wb_write_data = ^wb_write_data;

  // Without the bypass, wait one cycle and reread the committed value.
  assign wb_hazard = id_valid & wb_reg_write & (wb_write_reg != ZERO_REG) &
                     ((id_uses_rs1 & (id_rs1 == wb_write_reg)) |
                      (id_uses_rs2 & (id_rs2 == wb_write_reg)));
`endif

  assign load_use = ex_valid_q & ex_mem_read_q & ex_reg_write_q &
                    (ex_rd_q != ZERO_REG) & id_valid &
                    ((id_uses_rs1 & (id_rs1 == ex_rd_q)) |
                     (id_uses_rs2 & (id_rs2 == ex_rd_q)));

  assign hazard_stall = load_use | wb_hazard;

  // Priority: hold > flush > hazard bubble > load. Bubbles keep the data
  // fields unchanged; only the qualifying bits are cleared.
  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_op_a_d      = ex_op_a_q;
    ex_op_b_d      = ex_op_b_q;
    ex_imm_d       = ex_imm_q;
    ex_rd_d        = ex_rd_q;
    ex_reg_write_d = ex_reg_write_q;
    ex_mem_read_d  = ex_mem_read_q;
    ex_ctrl_d      = ex_ctrl_q;
    if (ex_hold) begin
      // retain everything
    end else if (flush || hazard_stall) begin
      ex_valid_d     = 1'b0;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
    end else begin
      ex_valid_d     = id_valid;
      ex_op_a_d      = op_a;
      ex_op_b_d      = op_b;
      ex_imm_d       = id_imm;
      ex_rd_d        = id_rd;
      ex_reg_write_d = id_reg_write & id_valid;
      ex_mem_read_d  = id_mem_read & id_valid;
      ex_ctrl_d      = id_ctrl;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q     <= 1'b0;
      ex_op_a_q      <= '0;
      ex_op_b_q      <= '0;
      ex_imm_q       <= '0;
      ex_rd_q        <= '0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_ctrl_q      <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_op_a_q      <= ex_op_a_d;
      ex_op_b_q      <= ex_op_b_d;
      ex_imm_q       <= ex_imm_d;
      ex_rd_q        <= ex_rd_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_ctrl_q      <= ex_ctrl_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_op_a      = ex_op_a_q;
  assign ex_op_b      = ex_op_b_q;
  assign ex_imm       = ex_imm_q;
  assign ex_rd        = ex_rd_q;
  assign ex_reg_write = ex_reg_write_q;
  assign ex_mem_read  = ex_mem_read_q;
  assign ex_ctrl      = ex_ctrl_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between the register-file read (decode) stage and execute.
- Captures the two 16-bit operands read from the 16-entry register file, the immediate, the destination and the control bundle.
- Resolves the write-then-read hazard against the register file's same-cycle writeback.
- Detects load-use hazards and inserts bubbles; honours downstream hold and flush.

Parameters:
- CTRL_W, 8, width of the opaque execute control bundle passed through unchanged.
- ZERO_REG, 0, index of the hard-wired zero register; never a bypass source or hazard source.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  decode stage holds a real instruction
- id_rs1, id_rs2  in  4  source register indices, the same values driven to the register file read ports
- id_uses_rs1, id_uses_rs2  in  1  instruction actually consumes that source
- rf_data1, rf_data2  in  16  register file read data for id_rs1/id_rs2
- id_imm  in  16  sign/zero-extended immediate
- id_rd  in  4  destination index
- id_reg_write  in  1  instruction writes id_rd
- id_mem_read  in  1  instruction is a load
- id_ctrl  in  CTRL_W  execute control bundle
- wb_reg_write, wb_write_reg[4], wb_write_data[16]  in  same nets that drive the register file write port
- ex_hold  in  1  downstream stall; hold all EX outputs
- flush  in  1  kill the instruction entering EX
- hazard_stall  out  1  combinational; upstream must hold the PC and the ID stage
- ex_valid  out  1
- ex_op_a, ex_op_b, ex_imm  out  16
- ex_rd  out  4
- ex_reg_write, ex_mem_read  out  1
- ex_ctrl  out  CTRL_W

Behaviour:
- Reset (reset=0, async): all ex_* outputs = 0. This includes ex_valid=0, so reset produces a bubble. hazard_stall then evaluates to 0.
- Reset deassertion mid-operation: the first rising edge after release loads normally.
- Operand select, per source (combinational):
  - bypass when wb_reg_write=1, wb_write_reg==id_rsN, and id_rsN!=ZERO_REG; the operand then takes wb_write_data.
  - otherwise the operand takes rf_dataN.
  - Rationale: the register file commits on the same edge this stage samples, so the bypass is required for the correct value.
- Load-use hazard:
  - hazard_stall = ex_valid & ex_mem_read & ex_reg_write & (ex_rd!=ZERO_REG) & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Per-edge update priority, highest first:
  1. ex_hold=1: all ex_* retained. The flush and hazard bubble are ignored this edge; flush must be reasserted once the hold releases.
  2. flush=1: ex_valid, ex_reg_write, ex_mem_read <= 0. Data fields don't-care; implement as hold.
  3. hazard_stall=1: bubble inserted (ex_valid, ex_reg_write, ex_mem_read <= 0).
  4. Otherwise: load the ID fields. ex_valid<=id_valid; ex_reg_write<=id_reg_write&id_valid; ex_mem_read<=id_mem_read&id_valid.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- A load-use stall lasts exactly one cycle. After the bubble, ex_mem_read=0, so hazard_stall drops. The load's result then reaches the instruction through later-stage forwarding, which is outside this block.
- Simultaneous wb write to the ZERO_REG index that matches a source: no bypass; the operand is the rf_data value (0).
- Both sources equal and bypassed: both operands take wb_write_data.

Optional Feature:
- WB_BYPASS_EN
- Defined: writeback bypass muxes present as described above.
- Undefined:
  - Operands always come from rf_dataN.
  - hazard_stall additionally asserts when id_valid & wb_reg_write & wb_write_reg!=ZERO_REG & (id_uses_rs1 & id_rs1==wb_write_reg | id_uses_rs2 & id_rs2==wb_write_reg).
  - The instruction waits one cycle and rereads the committed value.

Test Plan:
- Reset: drive reset=0 mid-stream with ex_valid=1 -> all ex_* = 0 immediately (async); release, id_valid=1, rs1=3, rf_data1=0x1234 -> next edge ex_valid=1, ex_op_a=0x1234.
- WB bypass (macro on): wb writes r5=0xBEEF while id_rs2=5, rf_data2=0x0001 -> ex_op_b=0xBEEF. Repeat with wb_write_reg=0, id_rs2=0 -> ex_op_b=rf_data2=0x0000.
- Load-use: EX holds a load to r4; ID uses rs1=4 -> hazard_stall=1 that cycle, next edge ex_valid=0; following edge the instruction loads, hazard_stall=0. Same with id_uses_rs1=0 -> no stall.
- Hold vs flush: ex_hold=1 and flush=1 together -> ex_* unchanged; next cycle ex_hold=0, flush=1 -> ex_valid=0, ex_reg_write=0.
- Macro off: wb writes r7 while id_rs1=7 -> hazard_stall=1 for one cycle, next cycle ex_op_a=rf_data1 (committed value 0x00AA).
- Pass-through: id_imm=0x8001, id_rd=9, id_ctrl=0xA5 -> next edge ex_imm=0x8001, ex_rd=9, ex_ctrl=0xA5.
